iicmb_txn_sequencer: RTL and testbench

//  Wishbone master that turns one-byte I2C transaction requests into the IICMB

---
 rtl/iicmb_txn_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_iicmb_txn_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iicmb_txn_sequencer.sv
// Wishbone master that turns one-byte I2C requests into the IICMB register
// command sequence (enable, set bus, start, address, data, stop).
module iicmb_txn_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int BW = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [BW-1:0]            req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic                     req_rw_i,
    input  logic [7:0]               req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [7:0]               rsp_rdata_o,
    output logic [2:0]               rsp_status_o,
    output logic                     busy_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [7:0] CSR_ENABLE  = 8'hC0;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_START   = 8'h04;
    localparam logic [7:0] CMD_STOP    = 8'h05;
    localparam logic [7:0] CMD_SET_BUS = 8'h06;

    localparam logic [2:0] RSP_OK  = 3'd0;
    localparam logic [2:0] RSP_NAK = 3'd1;
    localparam logic [2:0] RSP_AL  = 3'd2;
    localparam logic [2:0] RSP_ERR = 3'd3;
    localparam logic [2:0] RSP_TMO = 3'd4;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_STEP, ST_BUS, ST_WAIT, ST_STATUS, ST_RSP
    } state_t;

    // Each step is one Wishbone access; *_CMD steps are CMDR writes followed by an irq wait.
    typedef enum logic [3:0] {
        STP_CSR, STP_BUS_DPR, STP_BUS_CMD, STP_START_CMD, STP_ADDR_DPR,
        STP_ADDR_CMD, STP_DATA_DPR, STP_DATA_CMD, STP_READ_DPR, STP_STOP_CMD
    } step_t;

    state_t          state;
    step_t           step;
    logic            inited;
    logic [TW-1:0]   tmo_cnt;
    logic [BW-1:0]   bus_q;
    logic [6:0]      addr_q;
    logic            rw_q;
    logic [7:0]      wdata_q;
    logic [7:0]      rdata_q;
    logic [2:0]      pend_status;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_INIT;
            step         <= STP_CSR;
            inited       <= 1'b0;
            tmo_cnt      <= '0;
            bus_q        <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            pend_status  <= RSP_OK;
            req_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_status_o <= '0;
            busy_o       <= 1'b0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            dat_o        <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    step  <= STP_CSR;
                    state <= ST_STEP;
                end

                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        bus_q       <= req_bus_i;
                        addr_q      <= req_addr_i;
                        rw_q        <= req_rw_i;
                        wdata_q     <= req_wdata_i;
                        rdata_q     <= '0;
                        pend_status <= RSP_OK;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        step        <= inited ? STP_BUS_DPR : STP_CSR;
                        state       <= ST_STEP;
                    end
                end

                ST_STEP: begin
                    cyc_o <= 1'b1;
                    stb_o <= 1'b1;
                    we_o  <= 1'b1;
                    adr_o <= ADR_CMDR;
                    dat_o <= '0;
                    state <= ST_BUS;
                    case (step)
                        STP_CSR: begin
                            adr_o <= ADR_CSR;
                            dat_o <= WB_DATA_WIDTH'(CSR_ENABLE);
                        end
                        STP_BUS_DPR: begin
                            adr_o <= ADR_DPR;
                            dat_o <= WB_DATA_WIDTH'(bus_q);
                        end
                        STP_BUS_CMD:   dat_o <= WB_DATA_WIDTH'(CMD_SET_BUS);
                        STP_START_CMD: dat_o <= WB_DATA_WIDTH'(CMD_START);
                        STP_ADDR_DPR: begin
                            adr_o <= ADR_DPR;
                            dat_o <= WB_DATA_WIDTH'({addr_q, rw_q});
                        end
                        STP_ADDR_CMD:  dat_o <= WB_DATA_WIDTH'(CMD_WRITE);
                        STP_DATA_DPR: begin
                            adr_o <= ADR_DPR;
                            dat_o <= WB_DATA_WIDTH'(wdata_q);
                        end
                        STP_DATA_CMD:  dat_o <= WB_DATA_WIDTH'(rw_q ? CMD_READ : CMD_WRITE);
                        STP_READ_DPR: begin
                            we_o  <= 1'b0;
                            adr_o <= ADR_DPR;
                        end
                        default:       dat_o <= WB_DATA_WIDTH'(CMD_STOP);
                    endcase
                end

                // Controls drop on the edge that sees ack, which also gives the idle gap.
                ST_BUS: begin
                    if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        state <= ST_STEP;
                        case (step)
                            STP_CSR: begin
                                inited <= 1'b1;
                                if (busy_o) begin
                                    step <= STP_BUS_DPR;
                                end else begin
                                    req_ready_o <= 1'b1;
                                    state       <= ST_IDLE;
                                end
                            end
                            STP_BUS_DPR:  step <= STP_BUS_CMD;
                            STP_ADDR_DPR: step <= STP_ADDR_CMD;
                            STP_DATA_DPR: step <= STP_DATA_CMD;
                            STP_READ_DPR: begin
                                rdata_q <= dat_i[7:0];
                                step    <= STP_STOP_CMD;
                            end
                            default: begin
                                tmo_cnt <= '0;
                                state   <= ST_WAIT;
                            end
                        endcase
                    end
                end

                ST_WAIT: begin
                    if (irq_i) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b0;
                        adr_o <= ADR_CMDR;
                        dat_o <= '0;
                        state <= ST_STATUS;
                    end else if (tmo_cnt == TMO_LAST) begin
                        inited       <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= RSP_TMO;
                        rsp_rdata_o  <= '0;
                        state        <= ST_RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                // Status priority: arbitration lost, then error, then NAK, then done.
                ST_STATUS: begin
                    if (ack_i) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        state       <= ST_RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= '0;
                        if (dat_i[5]) begin
                            rsp_status_o <= RSP_AL;
                        end else if (dat_i[4]) begin
                            rsp_status_o <= RSP_ERR;
                        end else if (dat_i[6]) begin
                            if (step == STP_ADDR_CMD || (step == STP_DATA_CMD && !rw_q)) begin
                                pend_status <= RSP_NAK;
                                step        <= STP_STOP_CMD;
                                rsp_valid_o <= 1'b0;
                                state       <= ST_STEP;
                            end else begin
                                rsp_status_o <= RSP_ERR;
                            end
                        end else if (dat_i[7]) begin
                            rsp_valid_o <= 1'b0;
                            state       <= ST_STEP;
                            case (step)
                                STP_BUS_CMD:   step <= STP_START_CMD;
                                STP_START_CMD: step <= STP_ADDR_DPR;
                                STP_ADDR_CMD:  step <= rw_q ? STP_DATA_CMD : STP_DATA_DPR;
                                STP_DATA_CMD:  step <= rw_q ? STP_READ_DPR : STP_STOP_CMD;
                                STP_STOP_CMD: begin
                                    rsp_valid_o  <= 1'b1;
                                    rsp_status_o <= pend_status;
                                    rsp_rdata_o  <= (pend_status == RSP_OK && rw_q) ? rdata_q : 8'h00;
                                    state        <= ST_RSP;
                                end
                                default: begin
                                    rsp_valid_o  <= 1'b1;
                                    rsp_status_o <= RSP_ERR;
                                    state        <= ST_RSP;
                                end
                            endcase
                        end else begin
                            rsp_status_o <= RSP_ERR;
                        end
                    end
                end

                ST_RSP: begin
                    rsp_valid_o  <= 1'b0;
                    rsp_rdata_o  <= '0;
                    rsp_status_o <= '0;
                    busy_o       <= 1'b0;
                    req_ready_o  <= 1'b1;
                    state        <= ST_IDLE;
                end

                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_iicmb_txn_sequencer.sv
// Directed bench for iicmb_txn_sequencer with a small IICMB register model
// that acks every access one cycle late and raises irq on CMDR writes.
module tb_iicmb_txn_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [0:0] req_bus = 1'b0;
    logic [6:0] req_addr = '0;
    logic       req_rw = 1'b0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [2:0] rsp_status;
    logic       busy;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack = 1'b0;
    logic       irq = 1'b0;

    int checks = 0;
    int failures = 0;

    iicmb_txn_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .NUM_I2C_BUSSES(1), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bus_i(req_bus),
        .req_addr_i(req_addr), .req_rw_i(req_rw), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_status_o(rsp_status),
        .busy_o(busy), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
    );

    always #5 clk = ~clk;

    // Register model: addresses 0x7F are absent and NAK the address byte.
    logic [10:0] wb_log[$];
    int          tb_cycle = 0;
    int          cmdr_done_cycle = 0;
    int          irq_served = 0;
    int          irq_limit = -1;
    logic [7:0]  last_dpr = '0;
    logic [7:0]  cmdr_stat = 8'h80;
    logic        addr_phase = 1'b0;

    always @(posedge clk) begin
        tb_cycle <= tb_cycle + 1;
        if (ack) begin
            ack <= 1'b0;
        end else if (cyc_o && stb_o) begin
            ack <= 1'b1;
            wb_log.push_back({we_o, adr_o, dat_o});
            if (we_o && adr_o == 2'd1) begin
                last_dpr <= dat_o;
            end else if (we_o && adr_o == 2'd2) begin
                cmdr_done_cycle <= tb_cycle + 2;
                if (dat_o == 8'h04) addr_phase <= 1'b1;
                if (dat_o == 8'h01 && addr_phase) begin
                    addr_phase <= 1'b0;
                    cmdr_stat  <= (last_dpr[7:1] == 7'h7F) ? 8'h40 : 8'h80;
                end else begin
                    cmdr_stat <= 8'h80;
                end
                if (irq_limit < 0 || irq_served < irq_limit) begin
                    irq        <= 1'b1;
                    irq_served <= irq_served + 1;
                end
            end else if (!we_o) begin
                dat_i <= (adr_o == 2'd2) ? cmdr_stat : (adr_o == 2'd1) ? 8'hA5 : 8'h00;
                if (adr_o == 2'd2) irq <= 1'b0;
            end
        end
    end

    int          log_base = 0;
    logic [9:0]  wr_q[$];
    int          rd_cmdr, rd_dpr;

    task automatic collect();
        wr_q.delete();
        rd_cmdr = 0;
        rd_dpr  = 0;
        for (int i = log_base; i < wb_log.size(); i++) begin
            if (wb_log[i][10]) wr_q.push_back(wb_log[i][9:0]);
            else if (wb_log[i][9:8] == 2'd2) rd_cmdr++;
            else if (wb_log[i][9:8] == 2'd1) rd_dpr++;
        end
    endtask

    task automatic do_request(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                              output logic got, output logic [7:0] rdata, output logic [2:0] status,
                              output int rsp_cycle, output logic busy_at_rsp,
                              output logic ready_after, output logic busy_after);
        int n = 0;
        got = 1'b0; rdata = 'x; status = 'x; rsp_cycle = 0;
        busy_at_rsp = 1'bx; ready_after = 1'bx; busy_after = 1'bx;
        @(negedge clk);
        req_addr = addr; req_rw = rw; req_wdata = wdata; req_bus = 1'b0; req_valid = 1'b1;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        while (n < 300) begin
            if (rsp_valid) begin
                got = 1'b1; rdata = rsp_rdata; status = rsp_status;
                rsp_cycle = tb_cycle; busy_at_rsp = busy;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (got) begin
            @(negedge clk);
            ready_after = req_ready;
            busy_after  = busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cyc_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_cyc got=%b want=0", cyc_o); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        log_base = wb_log.size();
        rst = 1'b0;
    endtask

    task automatic test_init_csr();
        logic [10:0] first;
        repeat (12) @(negedge clk);
        first = (wb_log.size() > log_base) ? wb_log[log_base] : 11'h000;
        checks++; if (wb_log.size() - log_base !== 1) begin failures++; $display("[TB] FAIL init_access_count got=%0d want=1", wb_log.size() - log_base); end
        checks++; if (first !== {1'b1, 2'd0, 8'hC0}) begin failures++; $display("[TB] FAIL init_csr_write got=%h want=%h", first, {1'b1, 2'd0, 8'hC0}); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL init_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_write();
        logic [9:0] exp [8] = '{10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h15A, 10'h201, 10'h205};
        logic got, ra, rdy, ba; logic [7:0] rd; logic [2:0] st; int cyc;
        log_base = wb_log.size();
        do_request(7'h22, 1'b0, 8'h5A, got, rd, st, cyc, ba, rdy, ra);
        collect();
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL write_rsp_seen got=%b want=1", got); end
        checks++; if (st !== 3'd0) begin failures++; $display("[TB] FAIL write_status got=%0d want=0", st); end
        checks++; if (rd !== 8'h00) begin failures++; $display("[TB] FAIL write_rdata got=%h want=00", rd); end
        checks++; if (ba !== 1'b1) begin failures++; $display("[TB] FAIL write_busy_at_rsp got=%b want=1", ba); end
        checks++; if (wr_q.size() !== 8) begin failures++; $display("[TB] FAIL write_seq_len got=%0d want=8", wr_q.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [9:0] w = (i < wr_q.size()) ? wr_q[i] : 10'h3FF;
            checks++; if (w !== exp[i]) begin failures++; $display("[TB] FAIL write_seq[%0d] got=%h want=%h", i, w, exp[i]); end
        end
        checks++; if (rd_cmdr !== 5) begin failures++; $display("[TB] FAIL write_cmdr_reads got=%0d want=5", rd_cmdr); end
    endtask

    task automatic test_read();
        logic [9:0] exp [7] = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201, 10'h203, 10'h205};
        logic got, ra, rdy, ba; logic [7:0] rd; logic [2:0] st; int cyc;
        log_base = wb_log.size();
        do_request(7'h22, 1'b1, 8'h00, got, rd, st, cyc, ba, rdy, ra);
        collect();
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL read_rsp_seen got=%b want=1", got); end
        checks++; if (st !== 3'd0) begin failures++; $display("[TB] FAIL read_status got=%0d want=0", st); end
        checks++; if (rd !== 8'hA5) begin failures++; $display("[TB] FAIL read_rdata got=%h want=a5", rd); end
        checks++; if (rd_dpr !== 1) begin failures++; $display("[TB] FAIL read_dpr_reads got=%0d want=1", rd_dpr); end
        checks++; if (wr_q.size() !== 7) begin failures++; $display("[TB] FAIL read_seq_len got=%0d want=7", wr_q.size()); end
        for (int i = 0; i < 7; i++) begin
            logic [9:0] w = (i < wr_q.size()) ? wr_q[i] : 10'h3FF;
            checks++; if (w !== exp[i]) begin failures++; $display("[TB] FAIL read_seq[%0d] got=%h want=%h", i, w, exp[i]); end
        end
    endtask

    task automatic test_nak_back_to_back();
        logic [9:0] exp [6] = '{10'h100, 10'h206, 10'h204, 10'h1FE, 10'h201, 10'h205};
        logic got, ra, rdy, ba; logic [7:0] rd; logic [2:0] st; int cyc;
        log_base = wb_log.size();
        do_request(7'h7F, 1'b0, 8'h11, got, rd, st, cyc, ba, rdy, ra);
        collect();
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL nak_rsp_seen got=%b want=1", got); end
        checks++; if (st !== 3'd1) begin failures++; $display("[TB] FAIL nak_status got=%0d want=1", st); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("[TB] FAIL nak_ready_after got=%b want=1", rdy); end
        checks++; if (ra !== 1'b0) begin failures++; $display("[TB] FAIL nak_busy_after got=%b want=0", ra); end
        checks++; if (wr_q.size() !== 6) begin failures++; $display("[TB] FAIL nak_seq_len got=%0d want=6", wr_q.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [9:0] w = (i < wr_q.size()) ? wr_q[i] : 10'h3FF;
            checks++; if (w !== exp[i]) begin failures++; $display("[TB] FAIL nak_seq[%0d] got=%h want=%h", i, w, exp[i]); end
        end
        do_request(7'h22, 1'b0, 8'h3C, got, rd, st, cyc, ba, rdy, ra);
        checks++; if (got !== 1'b1 || st !== 3'd0) begin failures++; $display("[TB] FAIL after_nak_status got=%0d seen=%b want=0", st, got); end
    endtask

    task automatic test_timeout();
        logic got, ra, rdy, ba; logic [7:0] rd; logic [2:0] st; int cyc, lat;
        irq_limit = irq_served;
        log_base = wb_log.size();
        do_request(7'h22, 1'b0, 8'h5A, got, rd, st, cyc, ba, rdy, ra);
        collect();
        lat = cyc - cmdr_done_cycle;
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL tmo_rsp_seen got=%b want=1", got); end
        checks++; if (st !== 3'd4) begin failures++; $display("[TB] FAIL tmo_status got=%0d want=4", st); end
        checks++; if (got && (lat > 50 || lat < 45)) begin failures++; $display("[TB] FAIL tmo_latency got=%0d want=45..50", lat); end
        checks++; if (wr_q.size() !== 2) begin failures++; $display("[TB] FAIL tmo_seq_len got=%0d want=2", wr_q.size()); end
        irq_limit = -1;
        log_base = wb_log.size();
        do_request(7'h22, 1'b0, 8'h5A, got, rd, st, cyc, ba, rdy, ra);
        collect();
        checks++; if (st !== 3'd0) begin failures++; $display("[TB] FAIL post_tmo_status got=%0d want=0", st); end
        checks++; if ((wr_q.size() > 0 ? wr_q[0] : 10'h3FF) !== 10'h0C0) begin failures++; $display("[TB] FAIL post_tmo_csr got=%h want=0c0", wr_q.size() > 0 ? wr_q[0] : 10'h3FF); end
        checks++; if ((wr_q.size() > 1 ? wr_q[1] : 10'h3FF) !== 10'h100) begin failures++; $display("[TB] FAIL post_tmo_setbus got=%h want=100", wr_q.size() > 1 ? wr_q[1] : 10'h3FF); end
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        logic seen_rsp = 1'b0;
        irq_limit = irq_served + 3;
        log_base = wb_log.size();
        @(negedge clk);
        req_addr = 7'h22; req_rw = 1'b0; req_wdata = 8'h77; req_valid = 1'b1;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        collect();
        while (wr_q.size() < 7 && n < 300) begin @(negedge clk); n++; collect(); end
        checks++; if (wr_q.size() < 7) begin failures++; $display("[TB] FAIL mid_reach_data_wait got=%0d want=7", wr_q.size()); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (cyc_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_cyc got=%b want=0", cyc_o); end
        log_base = wb_log.size();
        rst = 1'b0;
        irq_limit = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        collect();
        checks++; if (seen_rsp !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_no_rsp got=%b want=0", seen_rsp); end
        checks++; if (wr_q.size() !== 1 || wr_q[0] !== 10'h0C0) begin failures++; $display("[TB] FAIL mid_reset_csr_replay count=%0d want=1 entry 0c0", wr_q.size()); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_ready got=%b want=1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_init_csr();
        test_write();
        test_read();
        test_nak_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=expired want=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
